// File: rtl/pb_field_encoder.sv
// Protobuf field encoder: emits a varint key, then a varint or
// little-endian fixed payload, one byte per accepted output beat.
module pb_field_encoder #(
  parameter int FIELD_ID_W = 5,
  parameter int VALUE_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [FIELD_ID_W-1:0] s_field_id,
  input  logic [2:0]            s_wire_type,
  input  logic [VALUE_W-1:0]    s_value,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [7:0]            m_data,
  output logic                  m_last,
  output logic                  err
);

  localparam int KW = FIELD_ID_W + 3;

  typedef enum logic [1:0] {
    IDLE,
    KEY,
    PAYLOAD
  } state_t;

  state_t        r_state;
  logic [KW-1:0] r_krem;
  logic [63:0]   r_vrem;
  logic [2:0]    r_wt;
  logic [3:0]    r_cnt;

  logic [KW-1:0] w_key;
  logic [63:0]   w_val;
  logic [63:0]   w_lat_val;
  logic [3:0]    w_lat_cnt;
  logic          w_legal;
  logic          w_fixed;
  logic          w_accept;
  logic          w_take;
  logic [7:0]    w_nxt_byte;
  logic          w_nxt_last;
  logic [63:0]   w_nxt_rem;
  logic [3:0]    w_nxt_cnt;

  function automatic logic [7:0] vbyte(input logic [63:0] x);
    return {|x[63:7], x[6:0]};
  endfunction

  assign w_key    = {s_field_id, s_wire_type};
  assign w_val    = 64'(s_value);
  assign w_accept = m_valid & m_ready;
  assign w_take   = s_valid & s_ready;
  assign w_fixed  = (r_wt == 3'd1) || (r_wt == 3'd5);

  always_comb begin
    w_legal   = 1'b0;
    w_lat_val = w_val;
    w_lat_cnt = 4'd0;
    unique case (1'b1)
      (s_wire_type == 3'd0),
      (s_wire_type == 3'd2): begin
        w_legal = 1'b1;
      end
      (s_wire_type == 3'd1): begin
        w_legal   = 1'b1;
        w_lat_cnt = 4'd8;
      end
      (s_wire_type == 3'd5): begin
        w_legal   = 1'b1;
        w_lat_val = {32'd0, w_val[31:0]};
        w_lat_cnt = 4'd4;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // Next payload byte, shared by the key->payload hop and payload steps
  always_comb begin
    w_nxt_byte = vbyte(r_vrem);
    w_nxt_last = ~|r_vrem[63:7];
    w_nxt_rem  = r_vrem >> 7;
    w_nxt_cnt  = r_cnt;
    if (w_fixed) begin
      w_nxt_byte = r_vrem[7:0];
      w_nxt_last = (r_cnt == 4'd1);
      w_nxt_rem  = r_vrem >> 8;
      w_nxt_cnt  = r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_krem  <= '0;
      r_vrem  <= '0;
      r_wt    <= '0;
      r_cnt   <= '0;
      s_ready <= 1'b1;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_take) begin
            if (w_legal) begin
              r_state <= KEY;
              s_ready <= 1'b0;
              m_valid <= 1'b1;
              m_data  <= vbyte(64'(w_key));
              m_last  <= 1'b0;
              r_krem  <= w_key >> 7;
              r_vrem  <= w_lat_val;
              r_wt    <= s_wire_type;
              r_cnt   <= w_lat_cnt;
            end else begin
              err <= 1'b1;
            end
          end
        end
        KEY: begin
          if (w_accept) begin
            if (m_data[7]) begin
              m_data <= vbyte(64'(r_krem));
              r_krem <= r_krem >> 7;
            end else begin
              r_state <= PAYLOAD;
              m_data  <= w_nxt_byte;
              m_last  <= w_nxt_last;
              r_vrem  <= w_nxt_rem;
              r_cnt   <= w_nxt_cnt;
            end
          end
        end
        PAYLOAD: begin
          if (w_accept) begin
            if (m_last) begin
              r_state <= IDLE;
              s_ready <= 1'b1;
              m_valid <= 1'b0;
              m_data  <= '0;
              m_last  <= 1'b0;
            end else begin
              m_data <= w_nxt_byte;
              m_last <= w_nxt_last;
              r_vrem <= w_nxt_rem;
              r_cnt  <= w_nxt_cnt;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pb_field_encoder.sv
// Bench for pb_field_encoder: directed wire-format vectors plus
// randomized fields checked against an arithmetic encoding model.
module tb_pb_field_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [4:0] s_field_id = '0;
  logic [2:0] s_wire_type = '0;
  logic [31:0] s_value = '0;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_last;
  logic       err;

  int ncmp = 0;
  int nbad = 0;

  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  bit c_timeout;
  int c_stall_bad;
  int c_ncyc;
  logic c_sr_after;
  logic c_mv_after;

  always #5 clk = ~clk;

  pb_field_encoder #(.FIELD_ID_W(5), .VALUE_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_field_id(s_field_id), .s_wire_type(s_wire_type),
    .s_value(s_value),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .err(err)
  );

  function automatic bit rdy(input int mode, input int k);
    if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  function automatic string qstr(input logic [8:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf(" %s%02h", q[i][8] ? "*" : "", q[i][7:0])};
    return s;
  endfunction

  function automatic bit same_stream();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Reference encoding: base-128 digits low first, fixed types as LE bytes
  function automatic void push_varint(input longint unsigned x);
    longint unsigned b;
    do begin
      b = x % 128;
      x = x / 128;
      exp_q.push_back(9'(x != 0 ? b + 128 : b));
    end while (x != 0);
  endfunction

  function automatic void build_exp(input int fid, input int wt,
                                    input longint unsigned val);
    logic [8:0] t;
    exp_q.delete();
    push_varint(longint'(fid) * 8 + longint'(wt));
    if (wt == 0 || wt == 2) push_varint(val);
    else if (wt == 5)
      for (int i = 0; i < 4; i++) exp_q.push_back(9'((val >> (8 * i)) % 256));
    else if (wt == 1)
      for (int i = 0; i < 8; i++) exp_q.push_back(9'((val >> (8 * i)) % 256));
    t = exp_q.pop_back();
    exp_q.push_back(t | 9'h100);
  endfunction

  task automatic send(input int fid, input int wt, input logic [31:0] val);
    int w = 0;
    @(negedge clk);
    while (!s_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    ncmp++;
    if (s_ready !== 1'b1) begin
      nbad++;
      $display("FAIL send_wait s_ready=%b want=1", s_ready);
    end
    s_valid     = 1'b1;
    s_field_id  = 5'(fid);
    s_wire_type = 3'(wt);
    s_value     = val;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic collect(input int mode);
    int k = 0;
    bit done = 0;
    bit prev_st = 0;
    logic [7:0] pd = '0;
    logic pl = 1'b0;
    got_q.delete();
    c_stall_bad = 0;
    c_ncyc = 0;
    m_ready = rdy(mode, 0);
    while (!done && k < 200) begin
      @(negedge clk);
      c_ncyc++;
      if (prev_st && (!m_valid || m_data !== pd || m_last !== pl)) c_stall_bad++;
      if (m_valid && m_ready) begin
        got_q.push_back({m_last, m_data});
        if (m_last) done = 1;
      end
      prev_st = m_valid && !m_ready;
      pd = m_data;
      pl = m_last;
      @(posedge clk);
      #1;
      k++;
      if (!done) m_ready = rdy(mode, k);
    end
    c_timeout = !done;
    @(negedge clk);
    c_sr_after = s_ready;
    c_mv_after = m_valid;
    m_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    ncmp++;
    if ({s_ready, m_valid, m_data, m_last, err} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      nbad++;
      $display("FAIL reset_state got sr=%b mv=%b md=%h ml=%b err=%b want 1 0 00 0 0",
               s_ready, m_valid, m_data, m_last, err);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_len_small();
    send(1, 2, 32'd3);
    collect(0);
    exp_q = '{9'h00A, 9'h103};
    ncmp++;
    if (c_timeout !== 1'b0 || same_stream() !== 1'b1) begin
      nbad++;
      $display("FAIL len_small got=%s want=%s", qstr(got_q), qstr(exp_q));
    end
    ncmp++;
    if (c_sr_after !== 1'b1 || c_mv_after !== 1'b0) begin
      nbad++;
      $display("FAIL len_small_ready_after sr=%b mv=%b want sr=1 mv=0", c_sr_after, c_mv_after);
    end
    ncmp++;
    if (c_ncyc !== 2) begin
      nbad++;
      $display("FAIL len_small_rate cycles=%0d want=2", c_ncyc);
    end
  endtask

  task automatic test_varint_300();
    send(4, 0, 32'd300);
    collect(0);
    exp_q = '{9'h020, 9'h0AC, 9'h102};
    ncmp++;
    if (c_timeout !== 1'b0 || same_stream() !== 1'b1) begin
      nbad++;
      $display("FAIL varint_300 got=%s want=%s", qstr(got_q), qstr(exp_q));
    end
  endtask

  task automatic test_key_two_byte();
    send(31, 0, 32'd0);
    collect(0);
    exp_q = '{9'h0F8, 9'h001, 9'h100};
    ncmp++;
    if (c_timeout !== 1'b0 || same_stream() !== 1'b1) begin
      nbad++;
      $display("FAIL key_two_byte got=%s want=%s", qstr(got_q), qstr(exp_q));
    end
  endtask

  task automatic test_i32_stall();
    send(2, 5, 32'h12345678);
    collect(1);
    exp_q = '{9'h015, 9'h078, 9'h056, 9'h034, 9'h112};
    ncmp++;
    if (c_timeout !== 1'b0 || same_stream() !== 1'b1) begin
      nbad++;
      $display("FAIL i32_stall got=%s want=%s", qstr(got_q), qstr(exp_q));
    end
    ncmp++;
    if (c_stall_bad !== 0) begin
      nbad++;
      $display("FAIL i32_stall_hold unstable=%0d want=0", c_stall_bad);
    end
  endtask

  task automatic test_max_and_illegal();
    int errs = 0;
    bit mv = 0;
    bit srlow = 0;
    send(1, 0, 32'hFFFF_FFFF);
    collect(0);
    exp_q = '{9'h008, 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 9'h10F};
    ncmp++;
    if (c_timeout !== 1'b0 || same_stream() !== 1'b1) begin
      nbad++;
      $display("FAIL varint_max got=%s want=%s", qstr(got_q), qstr(exp_q));
    end
    send(1, 3, 32'd7);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (err) errs++;
      if (m_valid) mv = 1;
      if (!s_ready) srlow = 1;
    end
    ncmp++;
    if (errs !== 1) begin
      nbad++;
      $display("FAIL illegal_err pulses=%0d want=1", errs);
    end
    ncmp++;
    if (mv !== 1'b0 || srlow !== 1'b0) begin
      nbad++;
      $display("FAIL illegal_quiet m_valid_seen=%b s_ready_low=%b want 0 0", mv, srlow);
    end
  endtask

  task automatic test_i64();
    logic [31:0] v = $urandom;
    send(7, 1, v);
    collect(2);
    build_exp(7, 1, longint'(v));
    ncmp++;
    if (c_timeout !== 1'b0 || same_stream() !== 1'b1) begin
      nbad++;
      $display("FAIL i64 got=%s want=%s", qstr(got_q), qstr(exp_q));
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b1;
    logic v1;
    m_ready = 1'b1;
    send(4, 0, 32'd300);
    @(negedge clk);
    @(negedge clk);
    b1 = m_data;
    v1 = m_valid;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    ncmp++;
    if (m_valid !== 1'b0 || v1 !== 1'b1 || b1 !== 8'hAC) begin
      nbad++;
      $display("FAIL reset_mid mv_after=%b byte2=%h v=%b want mv_after=0 byte2=ac v=1",
               m_valid, b1, v1);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(1, 2, 32'd3);
    collect(0);
    exp_q = '{9'h00A, 9'h103};
    ncmp++;
    if (c_timeout !== 1'b0 || same_stream() !== 1'b1) begin
      nbad++;
      $display("FAIL reset_mid_resume got=%s want=%s", qstr(got_q), qstr(exp_q));
    end
  endtask

  task automatic test_random();
    int wts[4] = '{0, 1, 2, 5};
    int fid;
    int wt;
    int mode;
    int stall_bad = 0;
    int sr_bad = 0;
    logic [31:0] v;
    for (int i = 0; i < 40; i++) begin
      fid  = $urandom_range(0, 31);
      wt   = wts[$urandom_range(0, 3)];
      v    = $urandom >> $urandom_range(0, 31);
      mode = $urandom_range(0, 2);
      send(fid, wt, v);
      collect(mode);
      build_exp(fid, wt, longint'(v));
      ncmp++;
      if (c_timeout !== 1'b0 || same_stream() !== 1'b1) begin
        nbad++;
        $display("FAIL random[%0d] f=%0d wt=%0d v=%h got=%s want=%s",
                 i, fid, wt, v, qstr(got_q), qstr(exp_q));
      end
      stall_bad += c_stall_bad;
      if (c_sr_after !== 1'b1) sr_bad++;
    end
    ncmp++;
    if (stall_bad !== 0 || sr_bad !== 0) begin
      nbad++;
      $display("FAIL random_hold unstable=%0d ready_late=%0d want 0 0", stall_bad, sr_bad);
    end
  endtask

  task automatic test_back_to_back();
    send(3, 0, 32'd1);
    collect(0);
    build_exp(3, 0, 64'd1);
    ncmp++;
    if (c_timeout !== 1'b0 || same_stream() !== 1'b1) begin
      nbad++;
      $display("FAIL b2b_first got=%s want=%s", qstr(got_q), qstr(exp_q));
    end
    send(16, 2, 32'd200);
    collect(0);
    build_exp(16, 2, 64'd200);
    ncmp++;
    if (c_timeout !== 1'b0 || same_stream() !== 1'b1 || c_ncyc !== 4) begin
      nbad++;
      $display("FAIL b2b_second got=%s cycles=%0d want=%s cycles=4",
               qstr(got_q), c_ncyc, qstr(exp_q));
    end
  endtask

  initial begin
    test_reset();
    test_len_small();
    test_varint_300();
    test_key_two_byte();
    test_i32_stall();
    test_max_and_illegal();
    test_i64();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/pb_field_encoder.md
Name: pb_field_encoder

Overview:
Transmit-side counterpart of the tree decoder. It serialises one protobuf field header plus a scalar payload into a wire-format byte stream.
- Each accepted request carries field_id, wire_type and value.
- The block emits the varint key ((field_id<<3)|wire_type), then the payload: a varint for VARINT and for LEN (length prefix only), or little-endian bytes for I32/I64.
- It sits ahead of the byte-stream sink that feeds the decoder, so generated streams use the same field ids as the tree node table (Person = 1, PhoneNumber = 4).

Parameters:
- FIELD_ID_W, 5, width of field identifier; must match the decoder identifier width.
- VALUE_W, 32, payload width; legal range 8..64; varint byte count is at most ceil(VALUE_W/7).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  request valid
- s_ready  out  1  request accepted when s_valid & s_ready
- s_field_id  in  FIELD_ID_W  protobuf field number
- s_wire_type  in  3  0=VARINT, 1=I64, 2=LEN, 5=I32; others illegal
- s_value  in  VALUE_W  varint value, length prefix, or fixed payload
- m_valid  out  1  output byte valid
- m_ready  in  1  sink accepts byte
- m_data  out  8  output byte
- m_last  out  1  marks final byte of the field
- err  out  1  one-cycle pulse: illegal wire type dropped

Behaviour:
- Reset (async assert, sync-safe deassert). Outputs: s_ready=1, m_valid=0, m_data=0, m_last=0, err=0. FSM goes to IDLE and internal shift registers clear.
- FSM states: IDLE, KEY, PAYLOAD.
- IDLE:
  - s_ready=1. On handshake, latch the key as (field_id<<3)|wire_type (width FIELD_ID_W+3), the value and the wire_type.
  - Legal type: next state KEY; the first byte appears with m_valid=1 on the cycle after the handshake (latency 1).
  - Illegal type (3,4,6,7): err=1 on the next cycle, no bytes are emitted, and the FSM stays in IDLE.
- s_ready=0 in KEY and PAYLOAD. There is no overlap, so there is a one-cycle bubble between fields.
- Varint rule, applied to the key and to VARINT/LEN payloads:
  - Each byte is {cont, rem[6:0]}, after which rem >>= 7.
  - cont=1 if and only if the shifted rem is nonzero.
  - A value of 0 emits the single byte 0x00.
- KEY: emit key varint bytes. After the byte with cont=0 is accepted, go to PAYLOAD.
- PAYLOAD:
  - VARINT/LEN: emit the varint of the value.
  - I32: exactly 4 bytes, little-endian from value[31:0], zero-extended if VALUE_W<32.
  - I64: exactly 8 bytes, little-endian, zero-extended.
  - m_last=1 on the final payload byte. After that byte is accepted, return to IDLE.
- LEN does not stream the body. The caller follows with body bytes through a separate path.
- AXI-style handshake on the output side:
  - A byte advances only when m_valid & m_ready.
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable, and m_valid never deasserts.
- m_ready may be high constantly. The block then sustains 1 byte/cycle within a field.
- err is never asserted together with m_valid.
- Reset mid-field: output drops immediately (m_valid=0), the partial field is discarded, and there is no resume.

Test Plan:
- field_id=1, wt=2, value=3, m_ready=1 -> bytes 0x0A, 0x03; m_last only on 0x03; s_ready returns 1 the cycle after last.
- field_id=4, wt=0, value=300 -> 0x20, 0xAC, 0x02; m_last on 0x02.
- field_id=31, wt=0, value=0 -> 2-byte key 0xF8, 0x01, then 0x00 with m_last.
- field_id=2, wt=5, value=0x12345678, with m_ready toggled 1,0,0,1,... -> 0x15, 0x78, 0x56, 0x34, 0x12. m_data is stable across stalls and the order is unchanged.
- field_id=1, wt=0, value=0xFFFFFFFF -> 0x08, 0xFF, 0xFF, 0xFF, 0xFF, 0x0F. Then wt=3 -> a single err pulse with no m_valid, and s_ready stays 1.
- Assert rst_n=0 after the 2nd byte of the 300 case -> m_valid=0 immediately. A new request (field 1, wt 2, value 3) afterwards yields a clean 0x0A, 0x03.
